// File: rtl/sdram_ring_sequencer_pkg.sv
// Shared definitions for the SDRAM ring-buffer sequencer: FSM encoding,
// transfer direction and default tuning constants.
package sdram_ring_sequencer_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_ACK = 2'd1;
  localparam logic [1:0] ST_BUSY     = 2'd2;

  localparam int DEF_BURST_AW    = 15;
  localparam int DEF_IN_THRESH   = 120;
  localparam int DEF_OUT_THRESH  = 60;
  localparam int DEF_WR_RUN_MAX  = 4;
  localparam int DEF_ACK_TIMEOUT = 8;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_e;

endpackage

// File: rtl/sdram_ring_ptr.sv
// Write/read burst pointer pair for the SDRAM ring; the extra wrap bit
// distinguishes a full ring from an empty one.
module sdram_ring_ptr #(
  parameter int BURST_AW = 15
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inc_wr_i,
  input  logic                inc_rd_i,
  output logic [BURST_AW-1:0] wr_addr_o,
  output logic [BURST_AW-1:0] rd_addr_o,
  output logic [BURST_AW:0]   level_o,
  output logic                full_o,
  output logic                empty_o
);

  logic [BURST_AW:0] wr_ptr_q;
  logic [BURST_AW:0] rd_ptr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (inc_wr_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (inc_rd_i) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign wr_addr_o = wr_ptr_q[BURST_AW-1:0];
  assign rd_addr_o = rd_ptr_q[BURST_AW-1:0];
  // Modulo subtraction stays correct across the wrap of either pointer.
  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign full_o    = (wr_ptr_q[BURST_AW] != rd_ptr_q[BURST_AW]) &&
                     (wr_ptr_q[BURST_AW-1:0] == rd_ptr_q[BURST_AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);

endmodule

// File: rtl/sdram_ring_sequencer.sv
// Schedules burst writes/reads between the FIFOs and the SDRAM controller,
// treating SDRAM as a ring buffer, with write-run fairness and ack timeout.
module sdram_ring_sequencer
  import sdram_ring_sequencer_pkg::*;
#(
  parameter int BURST_AW    = DEF_BURST_AW,
  parameter int IN_THRESH   = DEF_IN_THRESH,
  parameter int OUT_THRESH  = DEF_OUT_THRESH,
  parameter int WR_RUN_MAX  = DEF_WR_RUN_MAX,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                sdram_clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clr_err,
  input  logic [7:0]          inusedw,
  input  logic [7:0]          outusedw,
  input  logic                sd_ready,
  output logic                wr_strobe,
  output logic                rd_strobe,
  output logic [BURST_AW-1:0] sd_addr,
  output logic [BURST_AW:0]   level,
  output logic                ring_full,
  output logic                ring_empty,
  output logic                timeout_err
);

  localparam int RUN_W = $clog2(WR_RUN_MAX + 1);
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [7:0]       IN_TH    = IN_THRESH[7:0];
  localparam logic [7:0]       OUT_TH   = OUT_THRESH[7:0];
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(WR_RUN_MAX);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(ACK_TIMEOUT);

  logic [1:0]          state_q, state_d;
  dir_e                dir_q, dir_d;
  logic                wr_strobe_q, wr_strobe_d;
  logic                rd_strobe_q, rd_strobe_d;
  logic [BURST_AW-1:0] addr_q, addr_d;
  logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                err_q, err_d;

  logic                inc_wr, inc_rd;
  logic [BURST_AW-1:0] wr_addr, rd_addr;
  logic                wr_ok, rd_ok;

  sdram_ring_ptr #(
    .BURST_AW (BURST_AW)
  ) u_ptr (
    .clk_i     (sdram_clk),
    .rst_i     (reset),
    .inc_wr_i  (inc_wr),
    .inc_rd_i  (inc_rd),
    .wr_addr_o (wr_addr),
    .rd_addr_o (rd_addr),
    .level_o   (level),
    .full_o    (ring_full),
    .empty_o   (ring_empty)
  );

  assign wr_ok = (inusedw >= IN_TH) && !ring_full;
  assign rd_ok = (outusedw <= OUT_TH) && !ring_empty;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    wr_strobe_d = 1'b0;
    rd_strobe_d = 1'b0;
    addr_d      = addr_q;
    run_cnt_d   = run_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    err_d       = err_q;
    inc_wr      = 1'b0;
    inc_rd      = 1'b0;

    // A timeout in the same cycle overrides this clear further down.
    if (clr_err) err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && sd_ready) begin
          if (rd_ok && ((run_cnt_q == RUN_MAX) || !wr_ok)) begin
            dir_d       = DIR_RD;
            rd_strobe_d = 1'b1;
            addr_d      = rd_addr;
            tmo_cnt_d   = '0;
            state_d     = ST_WAIT_ACK;
          end else if (wr_ok) begin
            dir_d       = DIR_WR;
            wr_strobe_d = 1'b1;
            addr_d      = wr_addr;
            tmo_cnt_d   = '0;
            state_d     = ST_WAIT_ACK;
          end
        end
      end
      ST_WAIT_ACK: begin
        if (!sd_ready) begin
          state_d = ST_BUSY;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (tmo_cnt_d == TMO_MAX) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_BUSY: begin
        if (sd_ready) begin
          state_d = ST_IDLE;
          if (dir_q == DIR_WR) begin
            inc_wr = 1'b1;
            if (run_cnt_q != RUN_MAX) run_cnt_d = run_cnt_q + 1'b1;
          end else begin
            inc_rd    = 1'b1;
            run_cnt_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_WR;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      addr_q      <= '0;
      run_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
      addr_q      <= addr_d;
      run_cnt_q   <= run_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      err_q       <= err_d;
    end
  end

  assign wr_strobe   = wr_strobe_q;
  assign rd_strobe   = rd_strobe_q;
  assign sd_addr     = addr_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_sdram_ring_sequencer.sv
// Directed bench: a default-size sequencer (A) and a 4-burst ring (B) for
// the full/wrap cases, each with a simple SDRAM controller responder.
module tb_sdram_ring_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, clr;
  logic [7:0]  inu_a, outu_a, inu_b, outu_b;
  logic        rdy_a, rdy_b, man_rdy_a, auto_rdy_a;
  logic        auto_a;
  logic        wr_a, rd_a, full_a, empty_a, terr_a;
  logic [14:0] addr_a;
  logic [15:0] lvl_a;
  logic        wr_b, rd_b, full_b, empty_b, terr_b;
  logic [1:0]  addr_b;
  logic [2:0]  lvl_b;

  int    checks = 0;
  int    errors = 0;
  string seq_a = "";
  string seq_b = "";
  int    addrs_a[$];
  int    addrs_b[$];
  int    busy_a, busy_b;

  sdram_ring_sequencer dut_a (
    .sdram_clk (clk), .reset (rst), .enable (en), .clr_err (clr),
    .inusedw (inu_a), .outusedw (outu_a), .sd_ready (rdy_a),
    .wr_strobe (wr_a), .rd_strobe (rd_a), .sd_addr (addr_a), .level (lvl_a),
    .ring_full (full_a), .ring_empty (empty_a), .timeout_err (terr_a)
  );

  sdram_ring_sequencer #(.BURST_AW(2)) dut_b (
    .sdram_clk (clk), .reset (rst), .enable (en), .clr_err (clr),
    .inusedw (inu_b), .outusedw (outu_b), .sd_ready (rdy_b),
    .wr_strobe (wr_b), .rd_strobe (rd_b), .sd_addr (addr_b), .level (lvl_b),
    .ring_full (full_b), .ring_empty (empty_b), .timeout_err (terr_b)
  );

  assign rdy_a = auto_a ? auto_rdy_a : man_rdy_a;

  // Controller model: after each strobe, ready drops for two cycles.
  initial begin
    auto_rdy_a = 1'b1;
    busy_a = 0;
    forever begin
      @(negedge clk);
      if (wr_a || rd_a) begin
        if (wr_a) seq_a = {seq_a, "W"}; else seq_a = {seq_a, "R"};
        addrs_a.push_back(int'(addr_a));
        busy_a = 2;
      end
      auto_rdy_a = (busy_a == 0);
      if (busy_a > 0) busy_a--;
    end
  end

  initial begin
    rdy_b = 1'b1;
    busy_b = 0;
    forever begin
      @(negedge clk);
      if (wr_b || rd_b) begin
        if (wr_b) seq_b = {seq_b, "W"}; else seq_b = {seq_b, "R"};
        addrs_b.push_back(int'(addr_b));
        busy_b = 2;
      end
      rdy_b = (busy_b == 0);
      if (busy_b > 0) busy_b--;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_strobe(input bit on_b, output logic [1:0] kind, output int addr);
    kind = 2'b00;
    addr = -1;
    for (int i = 0; i < 40 && kind == 2'b00; i++) begin
      @(negedge clk);
      if (on_b) begin
        kind = {wr_b, rd_b};
        addr = int'(addr_b);
      end else begin
        kind = {wr_a, rd_a};
        addr = int'(addr_a);
      end
    end
  endtask

  typedef struct {
    logic       en;
    logic [7:0] inu;
    logic [7:0] outu;
    logic [1:0] kind;
    int         addr;
    int         lvl;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [1:0] kind;
    int         addr;
    int         cnt;
    int         exp_addrs[15];

    // Ring state entering the table: level 0, wr_ptr 1, rd_ptr 1, run 0.
    vecs[0] = '{1'b0, 8'd200, 8'd0,   2'b00, 0, 0};
    vecs[1] = '{1'b1, 8'd0,   8'd0,   2'b00, 0, 0};
    vecs[2] = '{1'b1, 8'd120, 8'd255, 2'b10, 1, 1};
    vecs[3] = '{1'b1, 8'd0,   8'd61,  2'b00, 0, 1};
    vecs[4] = '{1'b1, 8'd255, 8'd60,  2'b10, 2, 2};
    vecs[5] = '{1'b1, 8'd0,   8'd60,  2'b01, 1, 1};
    vecs[6] = '{1'b1, 8'd119, 8'd0,   2'b01, 2, 0};
    vecs[7] = '{1'b1, 8'd130, 8'd0,   2'b10, 3, 1};
    vecs[8] = '{1'b1, 8'd119, 8'd61,  2'b00, 0, 1};
    vecs[9] = '{1'b1, 8'd0,   8'd0,   2'b01, 3, 0};
    exp_addrs = '{0, 1, 2, 3, 0, 4, 5, 6, 7, 1, 8, 9, 10, 11, 2};

    rst = 1'b1; en = 1'b0; clr = 1'b0;
    inu_a = 8'd0; outu_a = 8'd255; inu_b = 8'd0; outu_b = 8'd255;
    man_rdy_a = 1'b1; auto_a = 1'b0;
    tick(2);
    chk("reset_wr_strobe", int'(wr_a), 0);
    chk("reset_rd_strobe", int'(rd_a), 0);
    chk("reset_sd_addr", int'(addr_a), 0);
    chk("reset_level", int'(lvl_a), 0);
    chk("reset_empty", int'(empty_a), 1);
    chk("reset_full", int'(full_a), 0);
    chk("reset_timeout_err", int'(terr_a), 0);
    rst = 1'b0;
    tick(1);

    // Below both thresholds with an empty ring: nothing may start.
    en = 1'b1; inu_a = 8'd119; outu_a = 8'd60;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wr_a || rd_a) cnt++;
    end
    chk("idle_50_strobes", cnt, 0);

    // First write, controller driven by hand.
    inu_a = 8'd120; outu_a = 8'd255;
    tick(1);
    chk("w1_wr_strobe", int'(wr_a), 1);
    chk("w1_rd_strobe", int'(rd_a), 0);
    chk("w1_sd_addr", int'(addr_a), 0);
    inu_a = 8'd0; man_rdy_a = 1'b0;
    tick(1);
    chk("w1_strobe_one_cycle", int'(wr_a), 0);
    tick(1);
    chk("w1_level_while_busy", int'(lvl_a), 0);
    man_rdy_a = 1'b1;
    tick(1);
    chk("w1_level", int'(lvl_a), 1);
    chk("w1_empty", int'(empty_a), 0);
    $display("txn write addr=0 level=%0d", lvl_a);

    // First read at the outusedw boundary.
    auto_a = 1'b1; outu_a = 8'd60;
    tick(1);
    chk("r1_rd_strobe", int'(rd_a), 1);
    chk("r1_sd_addr", int'(addr_a), 0);
    outu_a = 8'd255;
    tick(4);
    chk("r1_level", int'(lvl_a), 0);
    chk("r1_empty", int'(empty_a), 1);
    $display("txn read addr=0 level=%0d", lvl_a);

    for (int v = 0; v < 10; v++) begin
      en = vecs[v].en; inu_a = vecs[v].inu; outu_a = vecs[v].outu;
      tick(1);
      chk($sformatf("vec%0d_strobes", v), int'({wr_a, rd_a}), int'(vecs[v].kind));
      if (vecs[v].kind != 2'b00) chk($sformatf("vec%0d_addr", v), int'(addr_a), vecs[v].addr);
      en = 1'b1; inu_a = 8'd0; outu_a = 8'd255;
      tick(5);
      chk($sformatf("vec%0d_level", v), int'(lvl_a), vecs[v].lvl);
      $display("txn vec %0d en=%0d in=%0d out=%0d level=%0d", v, vecs[v].en, vecs[v].inu,
               vecs[v].outu, lvl_a);
    end

    // Fairness: both eligible continuously from an empty ring.
    do_reset();
    seq_a = ""; addrs_a.delete();
    inu_a = 8'd200; outu_a = 8'd0;
    for (int i = 0; i < 100 && seq_a.len() < 15; i++) tick(1);
    inu_a = 8'd0; outu_a = 8'd255;
    tick(6);
    chk_str("fair_sequence", seq_a, "WWWWRWWWWRWWWWR");
    chk("fair_count", addrs_a.size(), 15);
    for (int i = 0; i < 15 && i < addrs_a.size(); i++)
      chk($sformatf("fair_addr%0d", i), addrs_a[i], exp_addrs[i]);
    chk("fair_level", int'(lvl_a), 9);
    $display("txn fairness seq=%s level=%0d", seq_a, lvl_a);

    // Acknowledge timeout: ready never falls.
    do_reset();
    auto_a = 1'b0; man_rdy_a = 1'b1;
    inu_a = 8'd120;
    tick(1);
    chk("to1_wr_strobe", int'(wr_a), 1);
    inu_a = 8'd0;
    tick(7);
    chk("to1_err_before", int'(terr_a), 0);
    tick(1);
    chk("to1_err_set", int'(terr_a), 1);
    chk("to1_level", int'(lvl_a), 0);
    tick(3);
    chk("to1_no_reissue", int'({wr_a, rd_a}), 0);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("to1_err_cleared", int'(terr_a), 0);
    $display("txn timeout cleared err=%0d", terr_a);

    // Clear held through a new timeout: the set must win.
    clr = 1'b1; inu_a = 8'd120;
    tick(1);
    chk("to2_sd_addr", int'(addr_a), 0);
    inu_a = 8'd0;
    tick(7);
    chk("to2_err_before", int'(terr_a), 0);
    tick(1);
    chk("to2_set_wins", int'(terr_a), 1);
    clr = 1'b0;
    tick(1);
    chk("to2_sticky", int'(terr_a), 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("to2_cleared", int'(terr_a), 0);

    // Reset asserted while the second write is in BUSY.
    inu_a = 8'd120;
    tick(1);
    inu_a = 8'd0; man_rdy_a = 1'b0;
    tick(1);
    man_rdy_a = 1'b1;
    tick(1);
    inu_a = 8'd120;
    tick(1);
    chk("rb_sd_addr", int'(addr_a), 1);
    inu_a = 8'd0; man_rdy_a = 1'b0;
    tick(2);
    chk("rb_level_before", int'(lvl_a), 1);
    #2 rst = 1'b1;
    #1;
    chk("rb_async_strobes", int'({wr_a, rd_a}), 0);
    chk("rb_async_addr", int'(addr_a), 0);
    chk("rb_async_level", int'(lvl_a), 0);
    chk("rb_async_empty", int'(empty_a), 1);
    man_rdy_a = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    chk("rb_idle_after", int'({wr_a, rd_a}), 0);
    inu_a = 8'd120;
    tick(1);
    chk("rb_restart_wr", int'(wr_a), 1);
    chk("rb_restart_addr", int'(addr_a), 0);
    inu_a = 8'd0;
    $display("txn reset-in-busy level=%0d", lvl_a);

    // Small ring: fill, read one, wrap-around write.
    do_reset();
    auto_a = 1'b1;
    seq_b = ""; addrs_b.delete();
    inu_b = 8'd200; outu_b = 8'd255;
    tick(30);
    chk_str("b_fill_sequence", seq_b, "WWWW");
    for (int i = 0; i < 4 && i < addrs_b.size(); i++)
      chk($sformatf("b_fill_addr%0d", i), addrs_b[i], i);
    chk("b_full", int'(full_b), 1);
    chk("b_full_level", int'(lvl_b), 4);
    inu_b = 8'd0; outu_b = 8'd0;
    wait_strobe(1'b1, kind, addr);
    chk("b_read_kind", int'(kind), 1);
    chk("b_read_addr", addr, 0);
    outu_b = 8'd255;
    tick(5);
    chk("b_after_read_level", int'(lvl_b), 3);
    chk("b_after_read_full", int'(full_b), 0);
    inu_b = 8'd200;
    wait_strobe(1'b1, kind, addr);
    chk("b_wrap_kind", int'(kind), 2);
    chk("b_wrap_addr", addr, 0);
    tick(5);
    chk("b_wrap_level", int'(lvl_b), 4);
    chk("b_wrap_full", int'(full_b), 1);
    tick(10);
    chk_str("b_final_sequence", seq_b, "WWWWRW");
    inu_b = 8'd0;
    $display("txn small ring seq=%s level=%0d", seq_b, lvl_b);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
